// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  // Next requester index, wrapping at n rather than at 2^ID_W.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
    return (int'(v) + 1 >= n) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req searching
// ptr, ptr+1, ... modulo num_req.
module rr_pick
  import uart_pkg::*;
#(
  parameter int num_req = 2
) (
  input  logic [num_req-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_REQ-1:0] req_ext;
  assign req_ext = MAX_REQ'(req);

  // NOTE: every output gets a value before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int          j;
    logic [ID_W-1:0] jj;
    any = |req;
    idx = '0;
    j   = 0;
    jj  = '0;
    // Walk from the farthest offset back to ptr so the nearest hit wins.
    for (int k = num_req - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= num_req) j = j - num_req;
      jj = ID_W'(j);
      if (req_ext[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one uart_sender among
// num_req byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int num_req      = 2,
  parameter int busy_timeout = 4,
  parameter int hold_timeout = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [num_req-1:0]        req_valid,
  input  logic [BYTE_W*num_req-1:0] req_data,
  input  logic [num_req-1:0]        req_last,
  output logic [num_req-1:0]        req_ready,
  output logic                      tx_send,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      grant_active,
  output logic [ID_W-1:0]           grant_id
);

  localparam int HOLD_W = (hold_timeout > 1) ? $clog2(hold_timeout) : 1;
  localparam int BUSY_W = (busy_timeout > 1) ? $clog2(busy_timeout) : 1;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    g_q, g_d;
  logic               last_q, last_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic               tx_send_q, tx_send_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [num_req-1:0] req_ready_q, req_ready_d;
  logic               grant_active_q, grant_active_d;

  logic                      pick_any;
  logic [ID_W-1:0]           pick_idx;
  logic [MAX_REQ-1:0]        valid_ext, last_ext, ready_ext;
  logic [BYTE_W*MAX_REQ-1:0] data_ext;

  assign valid_ext = MAX_REQ'(req_valid);
  assign last_ext  = MAX_REQ'(req_last);
  assign data_ext  = (BYTE_W*MAX_REQ)'(req_data);
  assign ready_ext = MAX_REQ'(1) << g_q;

  rr_pick #(.num_req(num_req)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    g_d            = g_q;
    last_d         = last_q;
    hold_cnt_d     = hold_cnt_q;
    busy_cnt_d     = busy_cnt_q;
    grant_active_d = grant_active_q;
    tx_send_d      = 1'b0;
    tx_data_d      = '0;
    req_ready_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          g_d            = pick_idx;
          grant_active_d = 1'b1;
          hold_cnt_d     = '0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        // A busy transmitter freezes the hold counter; only a silent holder ages.
        if (!tx_busy) begin
          if (valid_ext[g_q]) begin
            tx_send_d   = 1'b1;
            tx_data_d   = data_ext[int'(g_q)*BYTE_W +: BYTE_W];
            req_ready_d = ready_ext[num_req-1:0];
            last_d      = last_ext[g_q];
            hold_cnt_d  = '0;
            busy_cnt_d  = '0;
            state_d     = WAIT_BUSY;
          end else if (hold_cnt_q == HOLD_W'(hold_timeout - 1)) begin
            grant_active_d = 1'b0;
            g_d            = '0;
            ptr_d          = wrap_inc(g_q, num_req);
            hold_cnt_d     = '0;
            state_d        = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy || busy_cnt_q == BUSY_W'(busy_timeout - 1)) begin
          busy_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d          = wrap_inc(g_q, num_req);
            grant_active_d = 1'b0;
            g_d            = '0;
            state_d        = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values
  // computed for this cycle, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      g_q            <= '0;
      last_q         <= 1'b0;
      hold_cnt_q     <= '0;
      busy_cnt_q     <= '0;
      tx_send_q      <= 1'b0;
      tx_data_q      <= '0;
      req_ready_q    <= '0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      g_q            <= g_d;
      last_q         <= last_d;
      hold_cnt_q     <= hold_cnt_d;
      busy_cnt_q     <= busy_cnt_d;
      tx_send_q      <= tx_send_d;
      tx_data_q      <= tx_data_d;
      req_ready_q    <= req_ready_d;
      grant_active_q <= grant_active_d;
    end
  end

  assign tx_send      = tx_send_q;
  assign tx_data      = tx_data_q;
  assign req_ready    = req_ready_q;
  assign grant_active = grant_active_q;
  assign grant_id     = g_q;

endmodule
